// File: rtl/keypad_scan_reader_pkg.sv
// Shared types, key-code constants and helpers for the 4x4 keypad scanner.
// key_map() is only used when the design is built with KEYPAD_MAP_EN defined.
package keypad_scan_reader_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } kp_state_e;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Physical layout "123A / 456B / 789C / *0#D" to key value.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'd0:    code = 4'd1;
      4'd1:    code = 4'd2;
      4'd2:    code = 4'd3;
      4'd3:    code = KEY_A;
      4'd4:    code = 4'd4;
      4'd5:    code = 4'd5;
      4'd6:    code = 4'd6;
      4'd7:    code = KEY_B;
      4'd8:    code = 4'd7;
      4'd9:    code = 4'd8;
      4'd10:   code = 4'd9;
      4'd11:   code = KEY_C;
      4'd12:   code = KEY_STAR;
      4'd13:   code = 4'd0;
      4'd14:   code = KEY_HASH;
      4'd15:   code = KEY_D;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] col_drive(input logic [1:0] col);
    return ~(4'b0001 << col);
  endfunction

endpackage

// File: rtl/keypad_scan_reader_timer.sv
// Column window counter: counts 0..SCAN_DIV-1 and flags the last cycle of
// each window as the row sample tick.
module keypad_scan_timer #(
  parameter int SCAN_DIV = 32768
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_tick
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next window count with wrap at the last cycle.
  always_comb begin
    if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Window count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = (cnt_q == LAST);

endmodule

// File: rtl/keypad_scan_reader.sv
// 4x4 matrix keypad scanner with row synchronizer and single-key debounce.
// Define KEYPAD_MAP_EN to report layout-mapped key values instead of row*4+col.
module keypad_scan_reader
  import keypad_scan_reader_pkg::*;
#(
  parameter int SCAN_DIV     = 32768,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_row,
  output logic [3:0] o_col,
  output logic [3:0] o_key_code,
  output logic       o_key_valid,
  output logic       o_key_held
);

  localparam logic [3:0] DB_TARGET = 4'(DEBOUNCE_CNT);

  logic [3:0] row_meta_q, row_sync_q;
  logic       tick_s;
  kp_state_e  state_q, state_d;
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] col_drv_q, col_drv_d;
  logic [3:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       held_q, held_d;
  logic       any_low_s, cand_low_s;
  logic [1:0] low_row_s;
  logic [3:0] cnt_inc_s, new_code_s;

  keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_tick (tick_s)
  );

  assign any_low_s  = ~&row_sync_q;
  assign cand_low_s = ~row_sync_q[row_q];
  assign cnt_inc_s  = cnt_q + 4'd1;

  // Lowest-index active row wins when several rows are low.
  always_comb begin
    if (!row_sync_q[0]) begin
      low_row_s = 2'd0;
    end else if (!row_sync_q[1]) begin
      low_row_s = 2'd1;
    end else if (!row_sync_q[2]) begin
      low_row_s = 2'd2;
    end else begin
      low_row_s = 2'd3;
    end
  end

`ifdef KEYPAD_MAP_EN
  assign new_code_s = key_map(row_d, col_q);
`else
  assign new_code_s = {row_d, col_q};
`endif

  // Scan / debounce / held state machine; acts only on sample ticks.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    if (tick_s) begin
      case (state_q)
        ST_SCAN: begin
          if (any_low_s) begin
            row_d = low_row_s;
            if (DB_TARGET == 4'd1) begin
              state_d = ST_HELD;
              valid_d = 1'b1;
              cnt_d   = 4'd0;
            end else begin
              state_d = ST_DEBOUNCE;
              cnt_d   = 4'd1;
            end
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (cand_low_s) begin
            if (cnt_inc_s == DB_TARGET) begin
              state_d = ST_HELD;
              valid_d = 1'b1;
              cnt_d   = 4'd0;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            state_d = ST_SCAN;
            cnt_d   = 4'd0;
            col_d   = col_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (!cand_low_s) begin
            if (cnt_inc_s == DB_TARGET) begin
              state_d = ST_SCAN;
              cnt_d   = 4'd0;
              col_d   = col_q + 2'd1;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            cnt_d = 4'd0;
          end
        end
        default: begin
          state_d = ST_SCAN;
          cnt_d   = 4'd0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    code_d    = valid_d ? new_code_s : code_q;
    held_d    = (state_d == ST_HELD);
    col_drv_d = col_drive(col_d);
  end

  // Row synchronizer, FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= 4'b1111;
      row_sync_q <= 4'b1111;
      state_q    <= ST_SCAN;
      col_q      <= 2'd0;
      row_q      <= 2'd0;
      cnt_q      <= 4'd0;
      col_drv_q  <= 4'b1110;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      row_meta_q <= i_row;
      row_sync_q <= row_meta_q;
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      col_drv_q  <= col_drv_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
    end
  end

  assign o_col       = col_drv_q;
  assign o_key_code  = code_q;
  assign o_key_valid = valid_q;
  assign o_key_held  = held_q;

endmodule

// File: tb/tb_keypad_scan_reader.sv
// Directed bench for keypad_scan_reader with SCAN_DIV=4, DEBOUNCE_CNT=3 and a
// behavioural keypad that pulls a row low when its pressed key's column is driven.
module tb_keypad_scan_reader;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] i_row;
  logic [3:0] o_col;
  logic [3:0] o_key_code;
  logic       o_key_valid;
  logic       o_key_held;
  logic [15:0] key_mask = 16'h0000;

  int n_cmp = 0;
  int n_err = 0;

`ifdef KEYPAD_MAP_EN
  localparam logic [3:0] EXP_R1C2 = 4'd6;
  localparam logic [3:0] EXP_R2C0 = 4'd7;
  localparam logic [3:0] EXP_R0C3 = 4'd10;
  localparam logic [3:0] EXP_R3C1 = 4'd0;
`else
  localparam logic [3:0] EXP_R1C2 = 4'd6;
  localparam logic [3:0] EXP_R2C0 = 4'd8;
  localparam logic [3:0] EXP_R0C3 = 4'd3;
  localparam logic [3:0] EXP_R3C1 = 4'd13;
`endif

  keypad_scan_reader #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_row       (i_row),
    .o_col       (o_col),
    .o_key_code  (o_key_code),
    .o_key_valid (o_key_valid),
    .o_key_held  (o_key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    i_row = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_mask[r*4+c] && !o_col[c]) i_row[r] = 1'b0;
      end
    end
  end

  // Returns at the first negedge of a window in which o_col == pat.
  task automatic wait_col_entry(input logic [3:0] pat, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_col != pat) break;
    end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (o_col == pat) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_held_low(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (!o_key_held) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key_mask = 16'h0000;
    repeat (3) @(negedge clk);
    n_cmp++; if (o_col !== 4'b1110) begin n_err++; $display("FAIL reset_col: got %b want 1110", o_col); end
    n_cmp++; if (o_key_code !== 4'd0) begin n_err++; $display("FAIL reset_code: got %0d want 0", o_key_code); end
    n_cmp++; if (o_key_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_key_valid); end
    n_cmp++; if (o_key_held !== 1'b0) begin n_err++; $display("FAIL reset_held: got %b want 0", o_key_held); end
    rst_n = 1'b1;
  endtask

  task automatic test_scan;
    logic [3:0] pats [4];
    bit ok;
    pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011; pats[3] = 4'b0111;
    wait_col_entry(4'b1101, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL scan_timeout: got no 1101 window want one"); end
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (o_col !== pats[(1 + i / 4) % 4]) begin
        n_err++; $display("FAIL scan_col[%0d]: got %b want %b", i, o_col, pats[(1 + i / 4) % 4]);
      end
      n_cmp++; if (o_key_valid !== 1'b0) begin n_err++; $display("FAIL scan_valid[%0d]: got 1 want 0", i); end
    end
  endtask

  task automatic test_press;
    bit ok;
    int pulses;
    wait_col_entry(4'b1011, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL press_sync: got no 1011 window want one"); end
    key_mask = 16'h0040;
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i <= 12) begin
        n_cmp++;
        if (o_key_valid !== (i == 12)) begin n_err++; $display("FAIL press_valid[%0d]: got %b want %b", i, o_key_valid, (i == 12)); end
      end else begin
        pulses += int'(o_key_valid);
      end
      if (i == 12) begin
        n_cmp++; if (o_key_code !== EXP_R1C2) begin n_err++; $display("FAIL press_code: got %0d want %0d", o_key_code, EXP_R1C2); end
        n_cmp++; if (o_key_held !== 1'b1) begin n_err++; $display("FAIL press_held_start: got %b want 1", o_key_held); end
      end
      if (i == 30) begin
        n_cmp++; if (o_col !== 4'b1011) begin n_err++; $display("FAIL press_col_frozen: got %b want 1011", o_col); end
      end
    end
    key_mask = 16'h0000;
    for (int i = 41; i <= 56; i++) begin
      @(negedge clk);
      pulses += int'(o_key_valid);
      if (i <= 53) begin
        n_cmp++;
        if (o_key_held !== (i < 52)) begin n_err++; $display("FAIL release_held[%0d]: got %b want %b", i, o_key_held, (i < 52)); end
      end
      if (i == 52) begin
        n_cmp++; if (o_col !== 4'b0111) begin n_err++; $display("FAIL release_col: got %b want 0111", o_col); end
      end
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL press_extra_pulses: got %0d want 0", pulses); end
    n_cmp++; if (o_key_code !== EXP_R1C2) begin n_err++; $display("FAIL press_code_hold: got %0d want %0d", o_key_code, EXP_R1C2); end
  endtask

  task automatic test_glitch;
    bit ok;
    int pulses;
    wait_col_entry(4'b1110, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL glitch_sync: got no 1110 window want one"); end
    key_mask = 16'h0001;
    repeat (4) @(negedge clk);
    key_mask = 16'h0000;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      pulses += int'(o_key_valid);
      if (i == 3) begin
        n_cmp++; if (o_col !== 4'b1110) begin n_err++; $display("FAIL glitch_frozen: got %b want 1110", o_col); end
      end
      if (i == 4) begin
        n_cmp++; if (o_col !== 4'b1101) begin n_err++; $display("FAIL glitch_resume: got %b want 1101", o_col); end
      end
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
  endtask

  task automatic test_no_rollover;
    bit ok;
    int pulses;
    wait_col_entry(4'b1110, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL roll_sync: got no 1110 window want one"); end
    key_mask = 16'h0100;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_key_valid !== (i == 12)) begin n_err++; $display("FAIL roll_valid[%0d]: got %b want %b", i, o_key_valid, (i == 12)); end
    end
    n_cmp++; if (o_key_code !== EXP_R2C0) begin n_err++; $display("FAIL roll_code: got %0d want %0d", o_key_code, EXP_R2C0); end
    key_mask = 16'h8100;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pulses += int'(o_key_valid);
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL roll_second_pulse: got %0d want 0", pulses); end
    n_cmp++; if (o_key_code !== EXP_R2C0) begin n_err++; $display("FAIL roll_code_hold: got %0d want %0d", o_key_code, EXP_R2C0); end
    n_cmp++; if (o_key_held !== 1'b1) begin n_err++; $display("FAIL roll_held: got %b want 1", o_key_held); end
    n_cmp++; if (o_col !== 4'b1110) begin n_err++; $display("FAIL roll_col: got %b want 1110", o_col); end
    key_mask = 16'h0000;
    wait_held_low(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL roll_release_timeout: got held 1 want 0"); end
    n_cmp++; if (o_col !== 4'b1101) begin n_err++; $display("FAIL roll_resume_col: got %b want 1101", o_col); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    wait_col_entry(4'b0111, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_sync: got no 0111 window want one"); end
    key_mask = 16'h0008;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (o_col !== 4'b1110) begin n_err++; $display("FAIL rstmid_col: got %b want 1110", o_col); end
    n_cmp++; if (o_key_code !== 4'd0) begin n_err++; $display("FAIL rstmid_code: got %0d want 0", o_key_code); end
    n_cmp++; if (o_key_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", o_key_valid); end
    n_cmp++; if (o_key_held !== 1'b0) begin n_err++; $display("FAIL rstmid_held: got %b want 0", o_key_held); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_key_valid !== (i == 24)) begin n_err++; $display("FAIL rstmid_valid[%0d]: got %b want %b", i, o_key_valid, (i == 24)); end
    end
    n_cmp++; if (o_key_code !== EXP_R0C3) begin n_err++; $display("FAIL rstmid_fresh_code: got %0d want %0d", o_key_code, EXP_R0C3); end
    key_mask = 16'h0000;
    wait_held_low(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rstmid_release_timeout: got held 1 want 0"); end
  endtask

  task automatic test_map;
    bit ok;
    wait_col_entry(4'b1101, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL map_sync: got no 1101 window want one"); end
    key_mask = 16'h2000;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      n_cmp++;
      if (o_key_valid !== (i == 12)) begin n_err++; $display("FAIL map_valid[%0d]: got %b want %b", i, o_key_valid, (i == 12)); end
    end
    n_cmp++; if (o_key_code !== EXP_R3C1) begin n_err++; $display("FAIL map_code: got %0d want %0d", o_key_code, EXP_R3C1); end
    key_mask = 16'h0000;
    wait_held_low(ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL map_release_timeout: got held 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_press();
    test_glitch();
    test_no_rollover();
    test_reset_mid();
    test_map();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
